// File: rtl/dco_period_counter.sv
// DCO period counter: measures dco_clk cycles per reference pulse,
// reports signed error against fcw and derives a frequency-lock flag.
module dco_period_counter #(
  parameter int CNT_W    = 12,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic             dco_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ref_clk_pulse,
  input  logic [CNT_W-1:0] fcw,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W:0]   freq_err,
  output logic             err_valid,
  output logic             ovf,
  output logic             lock
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT
  } state_t;

  localparam int LC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CNT);
  localparam logic [CNT_W:0] TOL = (CNT_W + 1)'(LOCK_TOL);

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [LC_W-1:0] lock_cnt;

  logic             sat;
  logic [CNT_W-1:0] period;
  logic [CNT_W:0]   err;
  logic [CNT_W:0]   abs_err;
  logic             in_tol;
  logic             meas;
  logic [LC_W-1:0]  lc_inc;

  // Measurement arithmetic for the current pulse cycle
  always_comb begin
    sat     = (cnt == CNT_MAX);
    period  = sat ? cnt : cnt + 1'b1;
    err     = {1'b0, period} - {1'b0, fcw};
    abs_err = err[CNT_W] ? -err : err;
    in_tol  = !sat && (abs_err <= TOL);
    meas    = (state == COUNT) && enable
              && ref_clk_pulse;
    lc_inc  = (lock_cnt == LC_MAX) ? LC_MAX
              : lock_cnt + 1'b1;
  end

  // State register
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; disable always wins
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable) state_n = ARM;
      ARM: begin
        if (!enable)           state_n = IDLE;
        else if (ref_clk_pulse) state_n = COUNT;
      end
      COUNT: if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Period counter and measurement outputs
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      count     <= '0;
      freq_err  <= '0;
      err_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (state == ARM && enable && ref_clk_pulse) begin
        cnt <= '0;
      end else if (meas) begin
        count     <= period;
        freq_err  <= err;
        ovf       <= sat;
        err_valid <= 1'b1;
        cnt       <= '0;
      end else if (state == COUNT && enable && !sat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Lock qualification over consecutive good measurements
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (!enable) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (meas) begin
      if (in_tol) begin
        lock_cnt <= lc_inc;
        if (lc_inc == LC_MAX) lock <= 1'b1;
      end else begin
        lock_cnt <= '0;
        lock     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dco_period_counter.sv
// Directed bench for dco_period_counter.
// Hand-computed expectations, one task per scenario.
module tb_dco_period_counter;

  logic        dco_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ref_clk_pulse;
  logic [11:0] fcw;
  logic [11:0] count;
  logic [12:0] freq_err;
  logic        err_valid;
  logic        ovf;
  logic        lock;

  int vectors = 0;
  int miscompares = 0;

  dco_period_counter #(
    .CNT_W(12), .LOCK_TOL(2), .LOCK_CNT(8)
  ) dut (
    .dco_clk(dco_clk),
    .rst_n(rst_n),
    .enable(enable),
    .ref_clk_pulse(ref_clk_pulse),
    .fcw(fcw),
    .count(count),
    .freq_err(freq_err),
    .err_valid(err_valid),
    .ovf(ovf),
    .lock(lock)
  );

  always #5 dco_clk = ~dco_clk;

  task automatic tick();
    @(posedge dco_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    ref_clk_pulse = 1'b1;
    tick();
    ref_clk_pulse = 1'b0;
  endtask

  task automatic period(input int k);
    idle(k - 1);
    pulse();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    ref_clk_pulse = 1'b0;
    fcw = 12'd16;
    idle(2);
    vectors++;
    if ({count, freq_err, err_valid, ovf, lock} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%h/%b/%b/%b exp all 0",
               count, freq_err, err_valid, ovf, lock);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    enable = 1'b1;
    tick();
    pulse();
    vectors++;
    if (err_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arm_no_valid: got %b exp 0", err_valid);
    end
    for (int i = 0; i < 8; i++) begin
      period(16);
      vectors++;
      if (err_valid !== 1'b1 || count !== 12'd16 ||
          freq_err !== 13'd0 || lock !== (i == 7)) begin
        miscompares++;
        $display("FAIL lock_seq%0d: got v=%b c=%0d e=%h l=%b exp v=1 c=16 e=0 l=%b",
                 i, err_valid, count, freq_err, lock, i == 7);
      end
      if (i == 0) begin
        tick();
        vectors++;
        if (err_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL valid_width: got %b exp 0", err_valid);
        end
        idle(14);
        pulse();
        idle(0);
        i++;
        vectors++;
        if (err_valid !== 1'b1 || count !== 12'd16) begin
          miscompares++;
          $display("FAIL lock_seq1: got v=%b c=%0d exp v=1 c=16",
                   err_valid, count);
        end
      end
    end
  endtask

  task automatic test_unlock();
    period(19);
    vectors++;
    if (freq_err !== 13'd3 || lock !== 1'b0) begin
      miscompares++;
      $display("FAIL unlock_19: got e=%h l=%b exp e=0003 l=0",
               freq_err, lock);
    end
    period(18);
    vectors++;
    if (freq_err !== 13'd2 || lock !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_18: got e=%h l=%b exp e=0002 l=0",
               freq_err, lock);
    end
    for (int i = 0; i < 7; i++) begin
      period(16);
      vectors++;
      if (lock !== (i == 6)) begin
        miscompares++;
        $display("FAIL relock_seq%0d: got l=%b exp l=%b",
                 i, lock, i == 6);
      end
    end
  endtask

  task automatic test_negative();
    period(13);
    vectors++;
    if (err_valid !== 1'b1 || count !== 12'd13 ||
        freq_err !== 13'h1FFD || lock !== 1'b0) begin
      miscompares++;
      $display("FAIL neg_13: got v=%b c=%0d e=%h l=%b exp v=1 c=13 e=1ffd l=0",
               err_valid, count, freq_err, lock);
    end
    tick();
    vectors++;
    if (err_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL neg_width: got %b exp 0", err_valid);
    end
    idle(14);
    pulse();
  endtask

  task automatic test_back_to_back();
    pulse();
    vectors++;
    if (err_valid !== 1'b1 || count !== 12'd1 ||
        freq_err !== 13'h1FF1 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b: got v=%b c=%0d e=%h o=%b exp v=1 c=1 e=1ff1 o=0",
               err_valid, count, freq_err, ovf);
    end
  endtask

  task automatic test_saturation();
    period(5000);
    vectors++;
    if (count !== 12'd4095 || ovf !== 1'b1 ||
        freq_err !== 13'd4079 || lock !== 1'b0) begin
      miscompares++;
      $display("FAIL sat: got c=%0d o=%b e=%h l=%b exp c=4095 o=1 e=0fef l=0",
               count, ovf, freq_err, lock);
    end
    period(16);
    vectors++;
    if (count !== 12'd16 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_recover: got c=%0d o=%b exp c=16 o=0",
               count, ovf);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 8; i++) period(16);
    vectors++;
    if (lock !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_drop_lock: got %b exp 1", lock);
    end
    idle(10);
    fcw = 12'd20;
    idle(5);
    enable = 1'b0;
    pulse();
    vectors++;
    if (err_valid !== 1'b0 || lock !== 1'b0 || count !== 12'd16) begin
      miscompares++;
      $display("FAIL drop: got v=%b l=%b c=%0d exp v=0 l=0 c=16",
               err_valid, lock, count);
    end
    idle(3);
    pulse();
    vectors++;
    if (err_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_pulse: got %b exp 0", err_valid);
    end
    enable = 1'b1;
    tick();
    pulse();
    vectors++;
    if (err_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm: got %b exp 0", err_valid);
    end
    period(22);
    vectors++;
    if (err_valid !== 1'b1 || count !== 12'd22 || freq_err !== 13'd2) begin
      miscompares++;
      $display("FAIL after_rearm: got v=%b c=%0d e=%h exp v=1 c=22 e=0002",
               err_valid, count, freq_err);
    end
  endtask

  task automatic test_async_reset();
    idle(5);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({count, freq_err, err_valid, ovf, lock} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h/%h/%b/%b/%b exp all 0",
               count, freq_err, err_valid, ovf, lock);
    end
    #2 rst_n = 1'b1;
    tick();
    pulse();
    vectors++;
    if (err_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_arm: got %b exp 0", err_valid);
    end
    period(20);
    vectors++;
    if (err_valid !== 1'b1 || count !== 12'd20 || freq_err !== 13'd0) begin
      miscompares++;
      $display("FAIL post_reset_meas: got v=%b c=%0d e=%h exp v=1 c=20 e=0",
               err_valid, count, freq_err);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_negative();
    test_back_to_back();
    test_saturation();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
